// File: rtl/bnn_seq_ctrl.sv
// bnn_seq_ctrl: sequencer around the combinational BNN datapath.
// Loads a ROWSxCOLS binary image over a row stream, waits SETTLE_CYCLES for
// the datapath to settle, captures class scores plus argmax, and presents the
// result on a valid/ready port.
module bnn_seq_ctrl #(
  parameter int unsigned ROWS          = 32,
  parameter int unsigned COLS          = 32,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned NCLASS        = 4,
  parameter int unsigned SCORE_W       = 7
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        row_valid_i,
  output logic                        row_ready_o,
  input  logic [COLS-1:0]             row_data_i,
  output logic [ROWS*COLS-1:0]        img_o,
  input  logic [NCLASS*SCORE_W-1:0]   scores_i,
  output logic                        res_valid_o,
  input  logic                        res_ready_i,
  output logic [NCLASS*SCORE_W-1:0]   res_scores_o,
  output logic [$clog2(NCLASS)-1:0]   res_class_o,
  output logic                        busy_o,
  output logic [15:0]                 infer_cnt_o
);

  localparam int unsigned RCW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned SCW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned CLS_W = $clog2(NCLASS);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESULT = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic [RCW-1:0]               row_cnt_q, row_cnt_d;
  logic [SCW-1:0]               settle_cnt_q, settle_cnt_d;
  logic [ROWS*COLS-1:0]         img_q, img_d;
  logic [NCLASS*SCORE_W-1:0]    res_scores_q, res_scores_d;
  logic [CLS_W-1:0]             res_class_q, res_class_d;
  logic                         res_valid_q, res_valid_d;
  logic [15:0]                  infer_cnt_q, infer_cnt_d;

  logic [CLS_W-1:0]             best_idx;
  logic [SCORE_W-1:0]           best_val;

  // Argmax over live datapath scores; strict compare keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_val = scores_i[0 +: SCORE_W];
    for (int unsigned k = 1; k < NCLASS; k++) begin
      if (scores_i[k*SCORE_W +: SCORE_W] > best_val) begin
        best_val = scores_i[k*SCORE_W +: SCORE_W];
        best_idx = CLS_W'(k);
      end
    end
  end

  // Next-state logic: clear overrides everything, otherwise LOAD -> SETTLE -> RESULT.
  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    settle_cnt_d = settle_cnt_q;
    img_d        = img_q;
    res_scores_d = res_scores_q;
    res_class_d  = res_class_q;
    res_valid_d  = res_valid_q;
    infer_cnt_d  = infer_cnt_q;
    if (clear_i) begin
      state_d      = S_LOAD;
      row_cnt_d    = '0;
      settle_cnt_d = '0;
      res_valid_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (row_valid_i) begin
            img_d[row_cnt_q*COLS +: COLS] = row_data_i;
            if (row_cnt_q == RCW'(ROWS-1)) begin
              row_cnt_d    = '0;
              settle_cnt_d = SCW'(SETTLE_CYCLES-1);
              state_d      = S_SETTLE;
            end else begin
              row_cnt_d = row_cnt_q + 1'b1;
            end
          end
        end
        S_SETTLE: begin
          if (settle_cnt_q == '0) begin
            res_scores_d = scores_i;
            res_class_d  = best_idx;
            res_valid_d  = 1'b1;
            state_d      = S_RESULT;
          end else begin
            settle_cnt_d = settle_cnt_q - 1'b1;
          end
        end
        S_RESULT: begin
          if (res_ready_i) begin
            infer_cnt_d = infer_cnt_q + 16'd1;
            res_valid_d = 1'b0;
            state_d     = S_LOAD;
          end
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_LOAD;
      row_cnt_q    <= '0;
      settle_cnt_q <= '0;
      img_q        <= '0;
      res_scores_q <= '0;
      res_class_q  <= '0;
      res_valid_q  <= 1'b0;
      infer_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      img_q        <= img_d;
      res_scores_q <= res_scores_d;
      res_class_q  <= res_class_d;
      res_valid_q  <= res_valid_d;
      infer_cnt_q  <= infer_cnt_d;
    end
  end

  // Ready is gated by reset so the source sees no acceptance while reset is held.
  assign row_ready_o  = rst_ni && (state_q == S_LOAD);
  assign busy_o       = (state_q != S_LOAD);
  assign img_o        = img_q;
  assign res_valid_o  = res_valid_q;
  assign res_scores_o = res_scores_q;
  assign res_class_o  = res_class_q;
  assign infer_cnt_o  = infer_cnt_q;

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Testbench for bnn_seq_ctrl: randomized row streams and scores checked against
// a transaction-level model of image contents, latency, argmax and counter.
module tb_bnn_seq_ctrl;
  localparam int ROWS = 32;
  localparam int COLS = 32;
  localparam int S    = 8;
  localparam int NC   = 4;
  localparam int SW   = 7;

  logic                  clk_i;
  logic                  rst_ni;
  logic                  clear_i;
  logic                  row_valid_i;
  logic                  row_ready_o;
  logic [COLS-1:0]       row_data_i;
  logic [ROWS*COLS-1:0]  img_o;
  logic [NC*SW-1:0]      scores_i;
  logic                  res_valid_o;
  logic                  res_ready_i;
  logic [NC*SW-1:0]      res_scores_o;
  logic [1:0]            res_class_o;
  logic                  busy_o;
  logic [15:0]           infer_cnt_o;

  bnn_seq_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(S), .NCLASS(NC), .SCORE_W(SW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .row_valid_i(row_valid_i), .row_ready_o(row_ready_o), .row_data_i(row_data_i),
    .img_o(img_o), .scores_i(scores_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_scores_o(res_scores_o), .res_class_o(res_class_o),
    .busy_o(busy_o), .infer_cnt_o(infer_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int errs   = 0;
  int checks = 0;

  // Reference model state
  logic [COLS-1:0] exp_img [ROWS];
  int              mdl_row;
  logic [15:0]     exp_cnt;
  logic [NC*SW-1:0] exp_sc;
  logic [1:0]      exp_cls;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Argmax model: find the maximum value, then the first class holding it.
  function automatic logic [1:0] ref_argmax(input logic [NC*SW-1:0] sc);
    int mx;
    int v;
    mx = 0;
    for (int k = 0; k < NC; k++) begin
      v = int'(sc[k*SW +: SW]);
      if (v > mx) mx = v;
    end
    for (int k = NC-1; k >= 0; k--) begin
      v = int'(sc[k*SW +: SW]);
      if (v == mx) ref_argmax = 2'(k);
    end
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_img(input string tag);
    for (int r = 0; r < ROWS; r++) check(tag, img_o[r*COLS +: COLS], exp_img[r]);
  endtask

  // Present one row after a random number of idle cycles; it is accepted at the next edge.
  task automatic send_row(input logic [COLS-1:0] d, input int gap_pct);
    while (int'($urandom_range(99)) < gap_pct) begin
      row_valid_i = 1'b0;
      row_data_i  = $urandom;
      step();
    end
    row_valid_i = 1'b1;
    row_data_i  = d;
    check("row_ready_load", row_ready_o, 1);
    step();
    exp_img[mdl_row] = d;
    mdl_row++;
    row_valid_i = 1'b0;
  endtask

  // Full inference: load rows, settle with exact latency, hold result, then handshake or clear.
  task automatic run_infer(input logic [NC*SW-1:0] sc_in, input bit vary, input bit diag,
                           input int hold, input int gap_pct, input bit clr_in_result);
    logic [NC*SW-1:0] sc;
    for (int r = mdl_row; r < ROWS; r++)
      send_row(diag ? (32'h1 << r) : COLS'($urandom), gap_pct);
    mdl_row = 0;
    chk_img("img_load");
    sc = sc_in;
    for (int k = 1; k <= S; k++) begin
      if (vary) sc = {7'(k*5+1), 7'(k*3), 7'(k+9), 7'(k*7)};
      scores_i    = sc;
      row_valid_i = 1'($urandom);
      row_data_i  = $urandom;
      check("settle_valid", res_valid_o, 0);
      check("settle_busy", busy_o, 1);
      check("settle_ready", row_ready_o, 0);
      step();
    end
    exp_sc  = sc;
    exp_cls = ref_argmax(sc);
    row_valid_i = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      check("res_valid", res_valid_o, 1);
      check("res_scores", res_scores_o, exp_sc);
      check("res_class", res_class_o, exp_cls);
      check("res_ready_row", row_ready_o, 0);
      check("res_busy", busy_o, 1);
      scores_i    = NC*SW'($urandom);
      row_valid_i = 1'($urandom);
      row_data_i  = $urandom;
      if (h == hold) begin
        if (clr_in_result) clear_i = 1'b1;
        else res_ready_i = 1'b1;
      end
      step();
    end
    res_ready_i = 1'b0;
    clear_i     = 1'b0;
    row_valid_i = 1'b0;
    if (!clr_in_result) exp_cnt = exp_cnt + 16'd1;
    check("post_valid", res_valid_o, 0);
    check("post_cnt", infer_cnt_o, exp_cnt);
    check("post_ready", row_ready_o, 1);
    check("post_busy", busy_o, 0);
    check("post_scores", res_scores_o, exp_sc);
    check("post_class", res_class_o, exp_cls);
    chk_img("img_hold");
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_ready"}, row_ready_o, 0);
    check({tag, "_valid"}, res_valid_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_cnt"}, infer_cnt_o, 0);
    check({tag, "_scores"}, res_scores_o, 0);
    check({tag, "_class"}, res_class_o, 0);
    check({tag, "_img"}, (img_o == '0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni = 1'b1; clear_i = 1'b0; row_valid_i = 1'b0; row_data_i = '0;
    scores_i = '0; res_ready_i = 1'b0;
    for (int r = 0; r < ROWS; r++) exp_img[r] = '0;
    mdl_row = 0;
    exp_cnt = 16'd0;
    #1 rst_ni = 1'b0;
    #1 chk_reset_vals("rst0");
    step(); step();
    rst_ni = 1'b1;
    step();
    check("idle_ready", row_ready_o, 1);

    // Basic inference: diagonal image, class 2 wins
    run_infer({7'd10, 7'd50, 7'd3, 7'd20}, 1'b0, 1'b1, 3, 0, 1'b0);
    check("basic_class", res_class_o, 2);
    check("basic_cnt", infer_cnt_o, 1);
    // Ties
    run_infer({4{7'd64}}, 1'b0, 1'b0, 1, 20, 1'b0);
    check("tie_all", res_class_o, 0);
    run_infer({7'd5, 7'd9, 7'd9, 7'd1}, 1'b0, 1'b0, 0, 30, 1'b0);
    check("tie_pair", res_class_o, 1);
    // Backpressure with random row_valid during RESULT
    run_infer(NC*SW'($urandom), 1'b0, 1'b0, 20, 50, 1'b0);
    // Score isolation: scores change every settle cycle
    run_infer('0, 1'b1, 1'b0, 2, 0, 1'b0);
    // Random traffic
    for (int i = 0; i < 4; i++)
      run_infer(NC*SW'($urandom), 1'b0, 1'b0, int'($urandom_range(0, 5)),
                int'($urandom_range(0, 40)), 1'b0);

    // Clear after 17 rows; the beat alongside clear is dropped
    for (int r = 0; r < 17; r++) send_row(COLS'($urandom), 10);
    row_valid_i = 1'b1;
    row_data_i  = ~exp_img[17];
    clear_i     = 1'b1;
    step();
    clear_i     = 1'b0;
    row_valid_i = 1'b0;
    mdl_row     = 0;
    check("clr_busy", busy_o, 0);
    check("clr_ready", row_ready_o, 1);
    chk_img("img_clr");
    run_infer(NC*SW'($urandom), 1'b0, 1'b0, 1, 0, 1'b0);

    // Clear during RESULT
    run_infer(NC*SW'($urandom), 1'b0, 1'b0, 4, 0, 1'b1);

    // Asynchronous reset mid-SETTLE
    for (int r = 0; r < ROWS; r++) send_row(COLS'($urandom), 0);
    mdl_row = 0;
    step(); step();
    check("pre_rst_busy", busy_o, 1);
    #3 rst_ni = 1'b0;
    #1;
    for (int r = 0; r < ROWS; r++) exp_img[r] = '0;
    exp_cnt = 16'd0;
    chk_reset_vals("rst_mid");
    step();
    rst_ni = 1'b1;
    step();
    run_infer(NC*SW'($urandom), 1'b0, 1'b0, 1, 10, 1'b0);
    run_infer(NC*SW'($urandom), 1'b0, 1'b0, 2, 10, 1'b0);
    check("two_infer_cnt", infer_cnt_o, 2);

    // Counter wrap from 0xFFFF
    force dut.infer_cnt_q = 16'hFFFF;
    #1 release dut.infer_cnt_q;
    check("cnt_preload", infer_cnt_o, 16'hFFFF);
    exp_cnt = 16'hFFFF;
    run_infer(NC*SW'($urandom), 1'b0, 1'b0, 0, 0, 1'b0);
    check("cnt_wrap", infer_cnt_o, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
